wt_mem_req_arbiter: RTL and testbench
=====================================

WT_MEM_REQ_ARBITER -- requirements
Module: wt_mem_req_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstandingStores, default 7: ceiling on stores in flight.
REQ-002 SHALL have parameter MemTidWidth, default 2: transaction ID width.
REQ-003 SHALL have parameter AddrWidth, default 64: request address width.
REQ-004 SHALL have parameter DataWidth, default 64: store data width.
REQ-005 SHALL have port clk_i, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports req_valid_i / req_ready_o, input / output, [2:0] each: per-requester handshake (0 = icache miss, 1 = dcache load miss, 2 = write-buffer store).
REQ-008 SHALL have ports req_addr_i, input, [2:0][AddrWidth-1:0]; req_tid_i, input, [2:0][MemTidWidth-1:0]; req_wdata_i, input, DataWidth (requester 2 only).
REQ-009 SHALL have ports mem_req_o, output, 1; mem_gnt_i, input, 1: downstream request and its acceptance.
REQ-010 SHALL have ports mem_addr_o, AddrWidth; mem_wdata_o, DataWidth; mem_tid_o, MemTidWidth; mem_src_o, 2; mem_is_store_o, 1 (all outputs): payload of the held request.
REQ-011 SHALL have port store_ack_i, input, 1: one pulse per completed store.
REQ-012 SHALL have ports fence_i, input, 1, and fence_done_o, output, 1: drain request and one-cycle completion pulse.
REQ-013 SHALL have port stores_inflight_o, output, $clog2(MaxOutstandingStores+1): current store count.

Function
REQ-014 SHALL implement FSM IDLE, HOLD, DRAIN.
REQ-015 In IDLE, eligible requesters SHALL be arbitrated round-robin; the pointer SHALL advance past the winner only on acceptance.
REQ-016 Requester 2 SHALL be ineligible while stores_inflight_o == MaxOutstandingStores, in DRAIN, or while fence_i is high.
REQ-017 req_ready_o SHALL be high for the winner only, combinationally, and only in IDLE; an accepted request SHALL be registered, giving mem_req_o high from the next cycle (one-cycle latency), and the FSM SHALL enter HOLD.
REQ-018 In HOLD, mem_req_o and the payload SHALL stay stable until mem_gnt_i is high; the FSM SHALL then go to IDLE, or to DRAIN if fence_i is pending.
REQ-019 The store counter SHALL increment when a store is accepted in IDLE and decrement on store_ack_i; when both happen in the same cycle it SHALL stay unchanged.
REQ-020 store_ack_i with a count of 0 SHALL be ignored: the counter saturates at 0.
REQ-021 fence_i in IDLE SHALL enter DRAIN; fence_i in HOLD SHALL be latched and take effect after the grant.
REQ-022 In DRAIN, no request SHALL be accepted; when the count is 0, fence_done_o SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-023 fence_i in DRAIN with a count already at 0 SHALL complete in the next cycle.

Reset
REQ-024 On rst_ni low, asynchronously: FSM to IDLE, counter 0, RR pointer 0, pending fence cleared, mem_req_o 0, all payload outputs 0, fence_done_o 0, req_ready_o 0.

Configuration
REQ-025 With macro WT_MEM_ARB_STALL_CNT_EN defined, SHALL add output stall_cnt_o, 32-bit saturating, reset 0, counting cycles where requester 2 is valid but blocked by REQ-016.
REQ-026 Without WT_MEM_ARB_STALL_CNT_EN, stall_cnt_o and its logic SHALL be absent.

Structure
REQ-027 Requester index constants (ICACHE=0, DCACHE_LD=1, WBUF_ST=2) and the held-request struct typedef SHALL live in wt_cache_pkg.
REQ-028 Round-robin selection SHALL use common_cells rr_arb_tree as the single sub-module; FSM, counter and register stay in wt_mem_req_arbiter.

Verification
REQ-029 All three requesters valid in IDLE, mem_gnt_i high -> grants in order 0,1,2,0, each mem_req_o exactly one cycle after acceptance.
REQ-030 7 stores accepted with no acks -> requester 2 ready stays 0 at count 7; one store_ack_i -> count 6, next store accepted.
REQ-031 Store accepted in the same cycle as store_ack_i with count 3 -> count stays 3.
REQ-032 fence_i during HOLD with count 2, two acks 3 cycles apart -> no new acceptance; fence_done_o pulses once, one cycle after the count reaches 0.
REQ-033 mem_gnt_i held low 10 cycles in HOLD -> mem_addr_o/mem_tid_o unchanged across all cycles; rst_ni asserted mid-HOLD -> mem_req_o 0 and count 0 immediately.
REQ-034 With WT_MEM_ARB_STALL_CNT_EN, requester 2 blocked 5 cycles at the count limit -> stall_cnt_o == 5.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Shared definitions for the write-through cache memory-request path: requester
// indices, arbiter FSM states and the held-request record.
package wt_cache_pkg;

  localparam logic [1:0] ICACHE    = 2'd0;
  localparam logic [1:0] DCACHE_LD = 2'd1;
  localparam logic [1:0] WBUF_ST   = 2'd2;

  localparam int unsigned NumMemReq = 3;

  // Storage widths of the held request; wider arbiter parameters are truncated.
  localparam int unsigned MemReqAddrWidth = 64;
  localparam int unsigned MemReqDataWidth = 64;
  localparam int unsigned MemReqTidWidth  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StDrain
  } arb_state_e;

  typedef struct packed {
    logic                       valid;
    logic [1:0]                 src;
    logic                       is_store;
    logic [MemReqTidWidth-1:0]  tid;
    logic [MemReqAddrWidth-1:0] addr;
    logic [MemReqDataWidth-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arb_tree.sv
// Round-robin arbiter: the search starts at the pointer and the pointer moves
// one past the winner only when the downstream side grants.
module rr_arb_tree #(
  parameter int unsigned NumIn    = 3,
  parameter int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic [NumIn-1:0]    req_i,
  output logic [NumIn-1:0]    gnt_o,
  output logic                req_o,
  input  logic                gnt_i,
  output logic [IdxWidth-1:0] idx_o
);

  logic [IdxWidth-1:0] rr_q, rr_d;
  logic                found;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      if (!found && req_i[(32'(rr_q) + k) % NumIn]) begin
        found = 1'b1;
        idx_o = IdxWidth'((32'(rr_q) + k) % NumIn);
      end
    end
    req_o = |req_i;
    gnt_o = '0;
    if (gnt_i && req_o) gnt_o[idx_o] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (flush_i) begin
      rr_d = '0;
    end else if (req_o && gnt_i) begin
      rr_d = (idx_o == IdxWidth'(NumIn - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

endmodule

// File: rtl/wt_mem_req_arbiter.sv
// Arbitrates icache, dcache-load and write-buffer-store requests onto one memory port,
// limits stores in flight and implements fences. WT_MEM_ARB_STALL_CNT_EN adds stall_cnt_o.
module wt_mem_req_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned MaxOutstandingStores = 7,
  parameter int unsigned MemTidWidth          = 2,
  parameter int unsigned AddrWidth            = 64,
  parameter int unsigned DataWidth            = 64
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [2:0]                                  req_valid_i,
  output logic [2:0]                                  req_ready_o,
  input  logic [2:0][AddrWidth-1:0]                   req_addr_i,
  input  logic [2:0][MemTidWidth-1:0]                 req_tid_i,
  input  logic [DataWidth-1:0]                        req_wdata_i,
  output logic                                        mem_req_o,
  input  logic                                        mem_gnt_i,
  output logic [AddrWidth-1:0]                        mem_addr_o,
  output logic [DataWidth-1:0]                        mem_wdata_o,
  output logic [MemTidWidth-1:0]                      mem_tid_o,
  output logic [1:0]                                  mem_src_o,
  output logic                                        mem_is_store_o,
  input  logic                                        store_ack_i,
  input  logic                                        fence_i,
  output logic                                        fence_done_o,
`ifdef WT_MEM_ARB_STALL_CNT_EN
  output logic [31:0]                                 stall_cnt_o,
`endif
  output logic [$clog2(MaxOutstandingStores+1)-1:0]   stores_inflight_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstandingStores + 1);

  arb_state_e          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                fence_pend_q, fence_pend_d;
  logic                fence_done_q, fence_done_d;
  mem_req_t            req_q, req_d;

  logic       wbuf_ok, arb_go, arb_req, accept, store_inc, store_dec;
  logic [2:0] elig, arb_gnt;
  logic [1:0] win;

  assign wbuf_ok = (cnt_q != CntWidth'(MaxOutstandingStores)) && (state_q != StDrain) && !fence_i;
  assign elig    = req_valid_i & {wbuf_ok, 2'b11};
  // Gated by reset so no ready is offered while the block is held in reset.
  assign arb_go  = (state_q == StIdle) && rst_ni;

  rr_arb_tree #(
    .NumIn    (NumMemReq),
    .IdxWidth (2)
  ) u_rr_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .req_i   (elig),
    .gnt_o   (arb_gnt),
    .req_o   (arb_req),
    .gnt_i   (arb_go),
    .idx_o   (win)
  );

  assign req_ready_o = arb_gnt;
  assign accept      = arb_req && arb_go;
  assign store_inc   = accept && (win == WBUF_ST);
  assign store_dec   = store_ack_i && (cnt_q != '0);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    fence_pend_d = fence_pend_q;
    fence_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          req_d.valid    = 1'b1;
          req_d.src      = win;
          req_d.is_store = (win == WBUF_ST);
          req_d.tid      = MemReqTidWidth'(req_tid_i[win]);
          req_d.addr     = MemReqAddrWidth'(req_addr_i[win]);
          req_d.wdata    = (win == WBUF_ST) ? MemReqDataWidth'(req_wdata_i) : '0;
          fence_pend_d   = fence_i;
          state_d        = StHold;
        end else if (fence_i) begin
          state_d = StDrain;
        end
      end
      StHold: begin
        if (fence_i) fence_pend_d = 1'b1;
        if (mem_gnt_i) begin
          req_d.valid  = 1'b0;
          fence_pend_d = 1'b0;
          state_d      = (fence_pend_q || fence_i) ? StDrain : StIdle;
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          fence_done_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (store_inc && !store_dec)      cnt_d = cnt_q + 1'b1;
    else if (store_dec && !store_inc) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      fence_pend_q <= 1'b0;
      fence_done_q <= 1'b0;
      req_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fence_pend_q <= fence_pend_d;
      fence_done_q <= fence_done_d;
      req_q        <= req_d;
    end
  end

  assign mem_req_o         = req_q.valid;
  assign mem_addr_o        = AddrWidth'(req_q.addr);
  assign mem_wdata_o       = DataWidth'(req_q.wdata);
  assign mem_tid_o         = MemTidWidth'(req_q.tid);
  assign mem_src_o         = req_q.src;
  assign mem_is_store_o    = req_q.is_store;
  assign fence_done_o      = fence_done_q;
  assign stores_inflight_o = cnt_q;

`ifdef WT_MEM_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (req_valid_i[WBUF_ST] && !wbuf_ok && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Directed bench for wt_mem_req_arbiter: stimulus pushes expected memory requests into a
// scoreboard that a negedge monitor pops and compares when mem_req_o is presented.
module tb_wt_mem_req_arbiter;

  localparam logic [63:0] WData = 64'hDEAD_BEEF_CAFE_F00D;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [2:0]       req_valid, req_ready;
  logic [2:0][63:0] req_addr;
  logic [2:0][1:0]  req_tid;
  logic [63:0]      req_wdata;
  logic             mem_req, mem_gnt, mem_is_store;
  logic [63:0]      mem_addr, mem_wdata;
  logic [1:0]       mem_tid, mem_src;
  logic             store_ack, fence, fence_done;
  logic [2:0]       inflight;
`ifdef WT_MEM_ARB_STALL_CNT_EN
  logic [31:0]      stall_cnt;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  typedef struct {
    logic [1:0]  src;
    logic [63:0] addr;
    logic [1:0]  tid;
    logic        st;
    logic [63:0] wdata;
    int unsigned acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   presented = 1'b0;

  wt_mem_req_arbiter dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_addr_i        (req_addr),
    .req_tid_i         (req_tid),
    .req_wdata_i       (req_wdata),
    .mem_req_o         (mem_req),
    .mem_gnt_i         (mem_gnt),
    .mem_addr_o        (mem_addr),
    .mem_wdata_o       (mem_wdata),
    .mem_tid_o         (mem_tid),
    .mem_src_o         (mem_src),
    .mem_is_store_o    (mem_is_store),
    .store_ack_i       (store_ack),
    .fence_i           (fence),
    .fence_done_o      (fence_done),
`ifdef WT_MEM_ARB_STALL_CNT_EN
    .stall_cnt_o       (stall_cnt),
`endif
    .stores_inflight_o (inflight)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] addr_of(input int s);
    case (s)
      0:       return 64'h0000_0000_8000_1000;
      1:       return 64'h0000_0000_8000_2040;
      default: return 64'h0000_0000_9000_3080;
    endcase
  endfunction

  function automatic logic [1:0] tid_of(input int s);
    return 2'(s + 1);
  endfunction

  task automatic push(input int s);
    exp_t e;
    e.src   = 2'(s);
    e.addr  = addr_of(s);
    e.tid   = tid_of(s);
    e.st    = (s == 2);
    e.wdata = WData;
    e.acc   = cyc;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits to mid-cycle, checks the ready vector and records any acceptance.
  task automatic ready_is(input logic [2:0] exp_rdy, input string name);
    @(negedge clk);
    check(name, 64'(req_ready), 64'(exp_rdy));
    for (int s = 0; s < 3; s++) if (exp_rdy[s]) push(s);
  endtask

  always @(negedge clk) begin
    if (mem_req && !presented) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_req: got src %0d, want no request", mem_src);
      end else begin
        cur = sb.pop_front();
        check("mem_src", 64'(mem_src), 64'(cur.src));
        check("mem_addr", mem_addr, cur.addr);
        check("mem_tid", 64'(mem_tid), 64'(cur.tid));
        check("mem_is_store", 64'(mem_is_store), 64'(cur.st));
        if (cur.st) check("mem_wdata", mem_wdata, cur.wdata);
        check("req_latency", 64'(cyc), 64'(cur.acc + 1));
      end
      presented = 1'b1;
    end else if (mem_req) begin
      check("hold_addr", mem_addr, cur.addr);
      check("hold_tid", 64'(mem_tid), 64'(cur.tid));
      check("hold_src", 64'(mem_src), 64'(cur.src));
    end
    if (!mem_req || mem_gnt) presented = 1'b0;
  end

  initial begin
    rst_ni    = 1'b0;
    req_valid = 3'b111;
    for (int s = 0; s < 3; s++) begin
      req_addr[s] = addr_of(s);
      req_tid[s]  = tid_of(s);
    end
    req_wdata = WData;
    mem_gnt   = 1'b0;
    store_ack = 1'b0;
    fence     = 1'b0;

    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_fence_done", 64'(fence_done), 64'd0);
    check("rst_addr", mem_addr, 64'd0);
    check("rst_tid", 64'(mem_tid), 64'd0);
    check("rst_src", 64'(mem_src), 64'd0);
`ifdef WT_MEM_ARB_STALL_CNT_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    // Fence in IDLE with nothing outstanding completes through DRAIN.
    tick(); rst_ni = 1'b1; req_valid = 3'b000; fence = 1'b1;
    @(negedge clk); check("fidle_done_early", 64'(fence_done), 64'd0);
    tick(); fence = 1'b0; req_valid = 3'b001;
    ready_is(3'b000, "fidle_drain_ready");
    check("fidle_done_drain", 64'(fence_done), 64'd0);
    tick(); req_valid = 3'b000;
    @(negedge clk); check("fidle_done_pulse", 64'(fence_done), 64'd1);
    tick();
    @(negedge clk); check("fidle_done_clear", 64'(fence_done), 64'd0);

    // Round robin with all three requesting and an always-granting memory.
    mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); req_valid = 3'b111;
      ready_is(3'(3'b001 << (i % 3)), "rr_grant");
      tick(); if (i == 3) req_valid = 3'b000;
      ready_is(3'b000, "rr_hold_ready");
    end
    check("rr_inflight", 64'(inflight), 64'd1);
    tick(); store_ack = 1'b1; @(negedge clk);
    tick(); store_ack = 1'b0; @(negedge clk);
    check("rr_inflight_acked", 64'(inflight), 64'd0);

    // Fill to the store ceiling, stall, then free one slot.
    for (int k = 0; k < 7; k++) begin
      tick(); req_valid = 3'b100;
      ready_is(3'b100, "st_fill");
      tick(); if (k == 6) req_valid = 3'b000;
      ready_is(3'b000, "st_fill_hold");
    end
    check("st_full_cnt", 64'(inflight), 64'd7);
    for (int b = 0; b < 5; b++) begin
      tick(); req_valid = 3'b100;
      ready_is(3'b000, "st_full_ready");
    end
    tick(); req_valid = 3'b000; @(negedge clk);
`ifdef WT_MEM_ARB_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'd5);
`endif
    tick(); req_valid = 3'b100; store_ack = 1'b1;
    ready_is(3'b000, "st_ack_cycle_ready");
    tick(); store_ack = 1'b0;
    ready_is(3'b100, "st_after_ack");
    check("st_after_ack_cnt", 64'(inflight), 64'd6);
    tick(); req_valid = 3'b000; @(negedge clk);
    check("st_refill_cnt", 64'(inflight), 64'd7);

    // Store acceptance and ack in the same cycle leave the count alone.
    for (int a = 0; a < 4; a++) begin
      tick(); store_ack = 1'b1; @(negedge clk);
    end
    tick(); req_valid = 3'b100; store_ack = 1'b1;
    ready_is(3'b100, "same_cycle_accept");
    check("same_cycle_cnt_before", 64'(inflight), 64'd3);
    tick(); req_valid = 3'b000; store_ack = 1'b0; @(negedge clk);
    check("same_cycle_cnt_after", 64'(inflight), 64'd3);

    // Fence raised during HOLD with two stores outstanding.
    tick(); store_ack = 1'b1; @(negedge clk);
    tick(); store_ack = 1'b0; mem_gnt = 1'b0; req_valid = 3'b001;
    ready_is(3'b001, "fh_accept");
    check("fh_cnt", 64'(inflight), 64'd2);
    tick(); fence = 1'b1; req_valid = 3'b111;
    ready_is(3'b000, "fh_hold_ready");
    tick(); fence = 1'b0; mem_gnt = 1'b1;
    ready_is(3'b000, "fh_grant_ready");
    for (int d = 1; d <= 5; d++) begin
      tick(); store_ack = (d == 1) || (d == 4);
      ready_is(3'b000, "fh_drain_ready");
      check("fh_done_early", 64'(fence_done), 64'd0);
    end
    check("fh_cnt_zero", 64'(inflight), 64'd0);
    tick(); req_valid = 3'b000; store_ack = 1'b0;
    @(negedge clk); check("fh_done_pulse", 64'(fence_done), 64'd1);
    tick();
    @(negedge clk); check("fh_done_clear", 64'(fence_done), 64'd0);

    // Long HOLD with changing inputs, then reset in the middle of it.
    tick(); req_valid = 3'b100;
    ready_is(3'b100, "rs_store");
    tick(); req_valid = 3'b000; @(negedge clk);
    tick(); mem_gnt = 1'b0; req_valid = 3'b010;
    ready_is(3'b010, "rs_load");
    for (int h = 0; h < 10; h++) begin
      tick(); req_valid = 3'b000;
      req_addr[1] = addr_of(1) ^ 64'(h + 1);
      req_tid[1]  = 2'(h);
      @(negedge clk); check("rs_hold_req", 64'(mem_req), 64'd1);
    end
    check("rs_cnt_before_rst", 64'(inflight), 64'd1);
    tick(); rst_ni = 1'b0;
    #1;
    check("rs_async_mem_req", 64'(mem_req), 64'd0);
    check("rs_async_cnt", 64'(inflight), 64'd0);
    req_addr[1] = addr_of(1);
    req_tid[1]  = tid_of(1);
    tick(); rst_ni = 1'b1;
    tick();
    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
